bm_output_arbiter: RTL and testbench

Round-robin arbiter that shares one BondMachine output channel among several processor output ports. Each requester uses the valid/received handshake of a processor output (`oN`, `oN_valid`, `oN_received`). The arbiter forwards one word at a time to a single sink channel, such as the board-level LED/IO driver in `bondmachine_main`. It sits between the processor instances and the top-level I/O, and replaces direct `assign` wiring when several processors target one physical output.

---
 rtl/bm_output_arbiter.sv | 107 ++++++++++
 tb/tb_bm_output_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_output_arbiter.sv
// rtl/bm_output_arbiter.sv - round-robin arbiter sharing one BondMachine output among N_REQ processor outputs.
// Optional SEND-state watchdog enabled by defining BM_ARB_TIMEOUT_EN.
module bm_output_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clock_signal,
  input  logic                        reset_signal,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [N_REQ-1:0]            in_valid,
  output logic [N_REQ-1:0]            in_received,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_received,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_grant,
  output logic                        timeout_err
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] last;
  logic [GW-1:0] winner;
  logic          any_req;

  // Search starts just after the previous owner, so a requester that was
  // just served is considered last.
  always_comb begin
    winner  = '0;
    any_req = |in_valid;
    for (int k = N_REQ; k >= 1; k--) begin
      int j;
      j = (int'(last) + k) % N_REQ;
      if (in_valid[j]) winner = GW'(j);
    end
  end

`ifdef BM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock_signal or posedge reset_signal) begin
    if (reset_signal) begin
      state       <= IDLE;
      last        <= GW'(N_REQ - 1);
      out_grant   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      in_received <= '0;
`ifdef BM_ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            out_data  <= in_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            out_grant <= winner;
            last      <= winner;
            out_valid <= 1'b1;
            state     <= SEND;
`ifdef BM_ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        SEND: begin
          if (out_received) begin
            out_valid   <= 1'b0;
            in_received <= {{(N_REQ-1){1'b0}}, 1'b1} << out_grant;
            state       <= RELEASE;
          end
`ifdef BM_ARB_TIMEOUT_EN
          // Sink never answered: free the requester and drop the word.
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            out_valid   <= 1'b0;
            in_received <= {{(N_REQ-1){1'b0}}, 1'b1} << out_grant;
            timeout_err <= 1'b1;
            state       <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!in_valid[out_grant] && !out_received) begin
            in_received <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bm_output_arbiter.sv
// tb/tb_bm_output_arbiter.sv - self-checking bench for bm_output_arbiter (table vectors, sequences, random vs model).
// Honours BM_ARB_TIMEOUT_EN for the watchdog sequence.
module tb_bm_output_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clock_signal = 1'b0;
  logic          reset_signal = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_received;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_received = 1'b0;
  logic [1:0]    out_grant;
  logic          timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  bm_output_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clock_signal(clock_signal), .reset_signal(reset_signal),
    .in_data(in_data), .in_valid(in_valid), .in_received(in_received),
    .out_data(out_data), .out_valid(out_valid), .out_received(out_received),
    .out_grant(out_grant), .timeout_err(timeout_err)
  );

  always #5 clock_signal = ~clock_signal;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock_signal);
  endtask

  task automatic do_reset();
    reset_signal = 1'b1;
    in_valid     = '0;
    out_received = 1'b0;
    in_data      = '0;
    tick();
    tick();
    reset_signal = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_received"}, 32'(in_received), 32'h0);
    check({tag, "_out_valid"},   32'(out_valid),   32'h0);
    check({tag, "_out_data"},    32'(out_data),    32'h0);
    check({tag, "_out_grant"},   32'(out_grant),   32'h0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  // One complete word with an immediately responding sink and requester.
  task automatic run_txn(input logic [3:0] mask, input logic [31:0] data,
                         output logic [1:0] g, output logic [7:0] d);
    in_data  = data;
    in_valid = mask;
    tick();
    check("txn_latency_valid", 32'(out_valid), 32'h1);
    check("txn_no_recv_in_send", 32'(in_received), 32'h0);
    g = out_grant;
    d = out_data;
    out_received = 1'b1;
    tick();
    check("txn_valid_drop", 32'(out_valid), 32'h0);
    check("txn_recv_onehot", 32'(in_received), 32'(4'b0001 << g));
    in_valid     = '0;
    out_received = 1'b0;
    tick();
    check("txn_recv_release", 32'(in_received), 32'h0);
  endtask

  task automatic wait_out_valid(input string name);
    for (int w = 0; w < 20 && !out_valid; w++) tick();
    check(name, 32'(out_valid), 32'h1);
  endtask

  logic [1:0] g;
  logic [7:0] d;
  logic [1:0] exp_g;
  logic [7:0] held[N];
  logic [1:0] m_last;
  logic       prev_ov;
  int         delay, words, raises, pred;

  initial begin
    vecs[0] = '{4'b0001, 32'h000000A5, 2'd0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h13121110, 2'd1, 8'h11};
    vecs[2] = '{4'b1001, 32'h44332211, 2'd3, 8'h44};
    vecs[3] = '{4'b0001, 32'h000000C3, 2'd0, 8'hC3};
    vecs[4] = '{4'b0100, 32'h00770000, 2'd2, 8'h77};
    vecs[5] = '{4'b0110, 32'h005A6B00, 2'd1, 8'h6B};
    vecs[6] = '{4'b1000, 32'hE1000000, 2'd3, 8'hE1};
    vecs[7] = '{4'b0011, 32'h0000BBAA, 2'd0, 8'hAA};

    reset_signal = 1'b1;
    tick();
    check_idle_outputs("reset");
    reset_signal = 1'b0;
    tick();

    // Table vectors: round-robin order carried across entries.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].mask, vecs[i].data, g, d);
      check($sformatf("vec%0d_grant", i), 32'(g), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_data", i),  32'(d), 32'(vecs[i].exp_data));
    end

    // All requesters continuously valid: strict rotation 10,11,12,13,10...
    do_reset();
    in_data  = 32'h13121110;
    in_valid = 4'b1111;
    exp_g    = 2'd0;
    for (int i = 0; i < 8; i++) begin
      wait_out_valid("rr_wait");
      check("rr_grant", 32'(out_grant), 32'(exp_g));
      check("rr_data",  32'(out_data),  32'(8'h10 + 8'(exp_g)));
      g = out_grant;
      out_received = 1'b1;
      tick();
      check("rr_recv", 32'(in_received), 32'(4'b0001 << g));
      in_valid[g]  = 1'b0;
      out_received = 1'b0;
      tick();
      check("rr_recv_drop", 32'(in_received), 32'h0);
      in_valid[g] = 1'b1;
      exp_g = exp_g + 2'd1;
    end
    in_valid = '0;
    tick();
    tick();

    // Stalled sink: data and grant stay put, no acknowledge leaks out.
    do_reset();
    in_data  = 32'h00C70000;
    in_valid = 4'b0100;
    tick();
    check("stall_grant", 32'(out_grant), 32'h2);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("stall_hold", {out_valid, in_received, 3'b0, out_grant, 8'h0, out_data},
            {1'b1, 4'h0, 3'b0, 2'd2, 8'h0, 8'hC7});
    end
    out_received = 1'b1;
    tick();
    check("stall_ack", 32'(in_received), 32'h4);
    in_valid = '0;
    out_received = 1'b0;
    tick();

    // Asynchronous reset while in RELEASE with owner 2.
    do_reset();
    in_data  = 32'h00330000;
    in_valid = 4'b0100;
    tick();
    check("rst_mid_grant", 32'(out_grant), 32'h2);
    out_received = 1'b1;
    tick();
    check("rst_mid_release", 32'(in_received), 32'h4);
    #2 reset_signal = 1'b1;
    #1 check_idle_outputs("async_rst");
    tick();
    reset_signal = 1'b0;
    out_received = 1'b0;
    in_data  = 32'h00222100;
    in_valid = 4'b0110;
    tick();
    check("rst_priority_grant", 32'(out_grant), 32'h1);
    check("rst_priority_data",  32'(out_data),  32'h21);
    out_received = 1'b1;
    tick();
    in_valid = '0;
    out_received = 1'b0;
    tick();

    // Requester withdraws during SEND: delivered once, release follows sink.
    do_reset();
    in_data  = 32'h00005E00;
    in_valid = 4'b0010;
    tick();
    check("drop_send_valid", 32'(out_valid), 32'h1);
    in_valid = '0;
    tick();
    check("drop_send_hold", 32'(out_valid), 32'h1);
    check("drop_send_data", 32'(out_data), 32'h5E);
    out_received = 1'b1;
    tick();
    check("drop_recv", 32'(in_received), 32'h2);
    tick();
    check("drop_recv_held", 32'(in_received), 32'h2);
    out_received = 1'b0;
    tick();
    check("drop_release", 32'(in_received), 32'h0);
    tick();
    tick();
    check("drop_no_redeliver", 32'(out_valid), 32'h0);
    run_txn(4'b0010, 32'h00006100, g, d);
    check("drop_no_deadlock", 32'(d), 32'h61);

    // Sink never answers.
    do_reset();
    in_data  = 32'h000000F0;
    in_valid = 4'b0001;
    tick();
    check("to_valid", 32'(out_valid), 32'h1);
`ifdef BM_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("to_before_limit", 32'(out_valid), 32'h1);
    tick();
    check("to_valid_drop", 32'(out_valid), 32'h0);
    check("to_err", 32'(timeout_err), 32'h1);
    check("to_recv", 32'(in_received), 32'h1);
    in_valid = '0;
    tick();
    check("to_release", 32'(in_received), 32'h0);
    run_txn(4'b1000, 32'h9D000000, g, d);
    check("to_next_served", 32'(d), 32'h9D);
    check("to_err_sticky", 32'(timeout_err), 32'h1);
`else
    for (int i = 0; i < 40; i++) tick();
    check("to_valid_held", 32'(out_valid), 32'h1);
    check("to_err_zero", 32'(timeout_err), 32'h0);
    out_received = 1'b1;
    tick();
    in_valid = '0;
    out_received = 1'b0;
    tick();
    check("to_late_release", 32'(in_received), 32'h0);
`endif

    // Random traffic against a round-robin reference model.
    do_reset();
    m_last  = 2'd3;
    prev_ov = 1'b0;
    delay   = 0;
    words   = 0;
    raises  = 0;
    for (int cyc = 0; cyc < 2200; cyc++) begin
      tick();
      if ($countones(in_received) > 1)
        check("rand_onehot", 32'(in_received), 32'h0);
      if (out_valid && !prev_ov) begin
        pred = -1;
        for (int k = 1; k <= N; k++)
          if (pred < 0 && in_valid[(int'(m_last) + k) % N]) pred = (int'(m_last) + k) % N;
        check("rand_grant", 32'(out_grant), 32'(pred));
        if (pred >= 0) begin
          check("rand_data", 32'(out_data), 32'(held[pred]));
          m_last = 2'(pred);
        end
        words++;
      end
      prev_ov = out_valid;
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_received[i]) begin
          in_valid[i] = 1'b0;
        end else if (!in_valid[i] && !in_received[i] && cyc < 2000 && $urandom_range(0, 3) == 0) begin
          held[i] = 8'($urandom);
          in_data[i*DW +: DW] = held[i];
          in_valid[i] = 1'b1;
          raises++;
        end
      end
      if (out_valid && !out_received) begin
        if (delay == 0) out_received = 1'b1;
        else delay--;
      end else if (!out_valid && out_received) begin
        out_received = 1'b0;
        delay = $urandom_range(0, 3);
      end
    end
    check("rand_all_delivered", 32'(words), 32'(raises));
    check("rand_drained", {28'h0, in_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
